// File: rtl/debouncer.sv
// Push-button debouncer: two-flop synchroniser plus a stability counter that accepts a
// level change after 2^CNT_WIDTH agreeing samples. Define DEBOUNCER_EDGE_PULSE_EN for PB_down/PB_up.
module debouncer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic PB_state
`ifdef DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic PB_down,
  output logic PB_up
`endif
);

  logic                 sync0;
  logic                 sync1;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 differ;
  logic                 toggle;

  always_comb begin
    differ = (sync1 != PB_state);
    toggle = differ && (cnt == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= PB;
      sync1 <= sync0;
    end
  end

  // Any cycle of agreement restarts the count; saturation at all-ones is the accept point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      PB_state <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt      <= '0;
      PB_state <= ~PB_state;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef DEBOUNCER_EDGE_PULSE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PB_down <= 1'b0;
      PB_up   <= 1'b0;
    end else begin
      PB_down <= toggle && !PB_state;
      PB_up   <= toggle &&  PB_state;
    end
  end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: vector table, hand-written corner sequences,
// and randomized PB against a sliding-window reference model.
module tb_debouncer;

  localparam int unsigned W = 2;
  localparam int unsigned N = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb = 1'b0;
  logic pb_state;
  logic rst16_n = 1'b0;
  logic pb16 = 1'b0;
  logic state16;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic pb_down, pb_up, down16, up16;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  debouncer #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .PB(pb), .PB_state(pb_state)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    , .PB_down(pb_down), .PB_up(pb_up)
`endif
  );

  debouncer #(.CNT_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .PB(pb16), .PB_state(state16)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    , .PB_down(down16), .PB_up(up16)
`endif
  );

  // Reference model: PB seen two edges late; the level flips once the last N samples
  // since the previous flip or reset all disagree with it.
  logic m_d1, m_d2, m_state, m_down, m_up;
  logic win[$];

  task automatic model_edge(input logic r, input logic p);
    logic s;
    logic all_diff;
    if (!r) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_state = 1'b0; m_down = 1'b0; m_up = 1'b0;
      win.delete();
    end else begin
      s = m_d2;
      m_d2 = m_d1;
      m_d1 = p;
      m_down = 1'b0;
      m_up = 1'b0;
      win.push_back(s);
      if (win.size() > N) void'(win.pop_front());
      all_diff = (win.size() == N);
      foreach (win[i]) if (win[i] == m_state) all_diff = 1'b0;
      if (all_diff) begin
        m_state = ~m_state;
        m_down = m_state;
        m_up = ~m_state;
        win.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply current inputs across one rising edge, then return at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge(rst_n, pb);
    @(negedge clk);
  endtask

  typedef struct {
    logic r;
    logic p;
    logic exp_state;
    logic exp_down;
    logic exp_up;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    int unsigned hold;

    // Reset, clean rise (accepted on 6th edge), clean fall (accepted on 6th edge).
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 1'b1, (i >= 5), (i == 5), 1'b0});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 1'b0, (i < 5), 1'b0, (i == 5)});

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_n = v.r;
      pb = v.p;
      step();
      check($sformatf("vec%0d_state", i), pb_state, v.exp_state);
      if (!v.r) check($sformatf("vec%0d_cnt", i), dut.cnt, 0);
`ifdef DEBOUNCER_EDGE_PULSE_EN
      check($sformatf("vec%0d_down", i), pb_down, v.exp_down);
      check($sformatf("vec%0d_up", i), pb_up, v.exp_up);
`endif
    end

    // Bounce: 3 high, 1 low, four times, never enough to accept.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        pb = (k < 3);
        step();
        check($sformatf("bounce%0d_%0d", r, k), pb_state, 1'b0);
      end
    end
    pb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bounce_tail%0d", k), pb_state, 1'b0);
    end

    // Reset mid-count discards progress; a full recount is needed afterwards.
    pb = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("midrst_cnt_before", dut.cnt, 1);
    rst_n = 1'b0;
    step();
    check("midrst_cnt", dut.cnt, 0);
    check("midrst_state", pb_state, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("recount%0d", k), pb_state, (k == 5));
    end

    // Wide counter: toggling every 5 cycles never reaches 2^16.
    rst16_n = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst16_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      pb16 = ((k / 5) % 2) == 0;
      step();
      check($sformatf("wide%0d", k), state16, 1'b0);
`ifdef DEBOUNCER_EDGE_PULSE_EN
      check($sformatf("wide%0d_pulse", k), {down16, up16}, 2'b00);
`endif
    end

    // Randomized bursts against the reference model.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        pb = $urandom_range(1, 0);
        hold = $urandom_range(8, 1);
      end
      hold--;
      rst_n = ($urandom_range(99, 0) != 0);
      step();
      check($sformatf("rand%0d_state", k), pb_state, m_state);
`ifdef DEBOUNCER_EDGE_PULSE_EN
      check($sformatf("rand%0d_down", k), pb_down, m_down);
      check($sformatf("rand%0d_up", k), pb_up, m_up);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
